ext_host_port: RTL
==================

# ext_host_port

Host-side command engine driving the GPU core's external debug ports: instruction-RAM access, data-RAM access and register read-back. Accepts a byte stream of commands from a host link (UART/SPI front end) over a valid/ready handshake. Converts each command into single-cycle port transactions and returns responses as a byte stream. Loading a shader program, seeding data RAM and reading results all pass through this block.

## Interface
Parameters:
- ADDRESS_WIDTH, 16, inst/data RAM word-address width.
- READ_LATENCY, 1, clocks from the edge that registers a read address to valid read data; 1..3.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  command byte from host.
- in_valid  in  1  in_data valid.
- in_ready  out  1  engine accepts in_data this cycle.
- out_data  out  8  response byte to host.
- out_valid  out  1  out_data valid.
- out_ready  in  1  host accepts out_data.
- inst_ext_address  out  ADDRESS_WIDTH  inst RAM word address.
- inst_ext_write  out  1  inst RAM write strobe.
- inst_ext_in_data  out  32  inst RAM write data.
- inst_ext_out_data  in  32  inst RAM read data.
- data_ext_address, data_ext_write, data_ext_in_data, data_ext_out_data: same as inst_* for data RAM.
- reg_ext_address  out  5  register index.
- reg_ext_read  out  1  register read enable.
- reg_ext_out_data  in  32  register read data.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Command = opcode byte, then fields; all multi-byte fields little-endian.
- 0x01 inst write: addr(2), data(4). 0x02 inst read: addr(2). 0x03 data write: addr(2), data(4). 0x04 data read: addr(2). 0x05 reg read: index(1); bits 7:5 ignored.
- Addresses are truncated to ADDRESS_WIDTH.
- Write response: one byte 0xAA, emitted after the write strobe.
- Read response: 4 data bytes, LSB first.
- Unknown opcode: one byte 0xEE, then IDLE; its following bytes are parsed as new commands.
- States: IDLE → FIELDS (collect bytes, counter 0..5) → WRITE | READ_ISSUE → READ_WAIT (READ_LATENCY cycles) → RESP (drain response bytes) → IDLE. IDLE → RESP directly for unknown opcode.
- WRITE: exactly one cycle with the target *_ext_write=1; address and data stable that cycle.
- READ_ISSUE: address driven, *_ext_write=0. reg_ext_read=1 for reg reads only, held through READ_WAIT.
- Read data is captured into a 32-bit response register on the last READ_WAIT edge.
- Outside WRITE, both write strobes stay 0. Address and data outputs hold their last values.

## Timing
- Reset values: in_ready=0 during reset, then 1 in IDLE; out_valid=0, out_data=0; all strobes 0, reg_ext_read=0; addresses/data 0; busy=0; state IDLE.
- in_ready=1 only in IDLE/FIELDS; one byte consumed per cycle when in_valid&in_ready.
- Write latency: strobe on the cycle after the last field byte is accepted; 0xAA valid the next cycle.
- Read latency: READ_ISSUE is the cycle after the last field byte; data captured READ_LATENCY cycles later; first response byte valid the next cycle.
- Response: out_data/out_valid held stable until out_ready. One byte per handshake cycle; back-to-back bytes with out_ready held high.
- Reset mid-command: immediate abort, partial fields and pending response discarded, no strobe issued.

## Configuration
- EXT_HOST_BURST_EN defined: opcode 0x06 inst burst write: addr(2), count(2), then count×4 data bytes.
  - One inst_ext_write per word; address increments by 1, wrapping at 2^ADDRESS_WIDTH.
  - Single 0xAA after the last word. count=0 → no writes, 0xAA.
  - in_ready deasserts during each strobe cycle.
- Not defined: 0x06 is unknown → 0xEE.

## Test plan
- Reset with in_valid=1 → in_ready=0 during reset; all outputs at reset values; busy=0.
- Bytes 01 34 12 EF BE AD DE → one-cycle inst_ext_write, address 0x1234, data 0xDEADBEEF; then out byte 0xAA.
- Data RAM word 0x10 preloaded with 0x01020304, send 04 10 00 → responses 04,03,02,01; out_ready toggled 1/0 → each byte held until accepted.
- Bytes 05 E1 → reg_ext_address=1, reg_ext_read high for 1+READ_LATENCY cycles; response = reg x1 value.
- Bytes 7F then 02 00 00 → 0xEE, then the inst read completes normally; reset asserted mid-field (after 01 34) → no write strobe, next command parses cleanly.
- With EXT_HOST_BURST_EN: 06 FE FF 03 00 + 12 data bytes → writes at 0xFFFE, 0xFFFF, 0x0000, then a single 0xAA. Without the macro: 0xEE.

Source files
------------

// File: rtl/ext_host_port_if.sv
// Host byte-stream handshake plus inst/data RAM and register debug ports for ext_host_port.
// master = command engine side, slave = host link and GPU core side.
interface ext_host_port_if #(
  parameter int ADDRESS_WIDTH = 16
);
  logic [7:0]               in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [7:0]               out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDRESS_WIDTH-1:0] inst_ext_address;
  logic                     inst_ext_write;
  logic [31:0]              inst_ext_in_data;
  logic [31:0]              inst_ext_out_data;
  logic [ADDRESS_WIDTH-1:0] data_ext_address;
  logic                     data_ext_write;
  logic [31:0]              data_ext_in_data;
  logic [31:0]              data_ext_out_data;
  logic [4:0]               reg_ext_address;
  logic                     reg_ext_read;
  logic [31:0]              reg_ext_out_data;

  modport master (
    input  in_data, in_valid, out_ready,
           inst_ext_out_data, data_ext_out_data, reg_ext_out_data,
    output in_ready, out_data, out_valid,
           inst_ext_address, inst_ext_write, inst_ext_in_data,
           data_ext_address, data_ext_write, data_ext_in_data,
           reg_ext_address, reg_ext_read
  );

  modport slave (
    output in_data, in_valid, out_ready,
           inst_ext_out_data, data_ext_out_data, reg_ext_out_data,
    input  in_ready, out_data, out_valid,
           inst_ext_address, inst_ext_write, inst_ext_in_data,
           data_ext_address, data_ext_write, data_ext_in_data,
           reg_ext_address, reg_ext_read
  );
endinterface

// File: rtl/ext_host_port.sv
// Host command engine: parses a byte stream into inst/data RAM and register port transactions.
// Define EXT_HOST_BURST_EN to enable opcode 0x06 (inst RAM burst write).
module ext_host_port #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int READ_LATENCY  = 1
) (
  input  logic            clock,
  input  logic            reset,
  ext_host_port_if.master bus,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, FIELDS, WRITE, READ_ISSUE, READ_WAIT, RESP} state_t;

  localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

  state_t                   state, state_nx;
  logic [7:0]               opcode;
  logic [2:0]               cnt, need;
  logic [47:0]              fbuf, fnext;
  logic [1:0]               wait_cnt;
  logic [31:0]              resp;
  logic [2:0]               resp_left;
  logic [ADDRESS_WIDTH-1:0] inst_addr, data_addr;
  logic [31:0]              inst_wdata, data_wdata;
  logic [4:0]               reg_addr;
  logic                     accept, known, last_field, burst_more;
  logic                     in_ready_c, out_valid_c, inst_we, data_we, reg_re;

`ifdef EXT_HOST_BURST_EN
  logic        burst_data;
  logic [15:0] burst_left;
  assign burst_more = (opcode == 8'h06) && (burst_left != '0);
`else
  assign burst_more = 1'b0;
`endif

  assign accept     = bus.in_valid && (state == IDLE || state == FIELDS);
  assign last_field = (state == FIELDS) && accept && (cnt == need - 3'd1);

  always_comb begin
    known = 1'b0;
    case (bus.in_data)
      8'h01, 8'h02, 8'h03, 8'h04, 8'h05: known = 1'b1;
`ifdef EXT_HOST_BURST_EN
      8'h06: known = 1'b1;
`endif
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    need = 3'd4;
    case (opcode)
      8'h01, 8'h03: need = 3'd6;
      8'h02, 8'h04: need = 3'd2;
      8'h05:        need = 3'd1;
      default:      need = 3'd4;
    endcase
  end

  always_comb begin
    fnext = fbuf;
    fnext[{cnt, 3'b000} +: 8] = bus.in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    inst_we     = 1'b0;
    data_we     = 1'b0;
    reg_re      = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (accept) state_nx = known ? FIELDS : RESP;
      end
      FIELDS: begin
        in_ready_c = 1'b1;
        if (last_field) begin
          case (opcode)
            8'h01, 8'h03:        state_nx = WRITE;
            8'h02, 8'h04, 8'h05: state_nx = READ_ISSUE;
`ifdef EXT_HOST_BURST_EN
            // Header phase falls back into FIELDS to collect the first data word.
            8'h06: state_nx = burst_data ? WRITE :
                              (fnext[31:16] == '0) ? RESP : FIELDS;
`endif
            default:             state_nx = RESP;
          endcase
        end
      end
      WRITE: begin
        inst_we  = (opcode == 8'h01) || (opcode == 8'h06);
        data_we  = (opcode == 8'h03);
        state_nx = burst_more ? FIELDS : RESP;
      end
      READ_ISSUE: begin
        reg_re   = (opcode == 8'h05);
        state_nx = READ_WAIT;
      end
      READ_WAIT: begin
        reg_re = (opcode == 8'h05);
        if (wait_cnt == WAIT_LAST) state_nx = RESP;
      end
      RESP: begin
        out_valid_c = 1'b1;
        if (bus.out_ready && resp_left == 3'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opcode     <= '0;
      cnt        <= '0;
      fbuf       <= '0;
      wait_cnt   <= '0;
      resp       <= '0;
      resp_left  <= '0;
      inst_addr  <= '0;
      data_addr  <= '0;
      inst_wdata <= '0;
      data_wdata <= '0;
      reg_addr   <= '0;
`ifdef EXT_HOST_BURST_EN
      burst_data <= 1'b0;
      burst_left <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          opcode <= bus.in_data;
          cnt    <= '0;
`ifdef EXT_HOST_BURST_EN
          burst_data <= 1'b0;
`endif
          if (!known) begin
            resp      <= 32'h0000_00EE;
            resp_left <= 3'd1;
          end
        end
        FIELDS: if (accept) begin
          fbuf <= fnext;
          cnt  <= last_field ? 3'd0 : cnt + 3'd1;
          if (last_field) begin
            case (opcode)
              8'h01: begin
                inst_addr  <= ADDRESS_WIDTH'(fnext[15:0]);
                inst_wdata <= fnext[47:16];
              end
              8'h02: inst_addr <= ADDRESS_WIDTH'(fnext[15:0]);
              8'h03: begin
                data_addr  <= ADDRESS_WIDTH'(fnext[15:0]);
                data_wdata <= fnext[47:16];
              end
              8'h04: data_addr <= ADDRESS_WIDTH'(fnext[15:0]);
              8'h05: reg_addr  <= fnext[4:0];
`ifdef EXT_HOST_BURST_EN
              8'h06: begin
                if (!burst_data) begin
                  inst_addr  <= ADDRESS_WIDTH'(fnext[15:0]);
                  burst_left <= fnext[31:16];
                  burst_data <= 1'b1;
                  if (fnext[31:16] == '0) begin
                    resp      <= 32'h0000_00AA;
                    resp_left <= 3'd1;
                  end
                end else begin
                  inst_wdata <= fnext[31:0];
                  burst_left <= burst_left - 16'd1;
                end
              end
`endif
              default: ;
            endcase
          end
        end
        WRITE: begin
          if (burst_more) inst_addr <= inst_addr + ADDRESS_WIDTH'(1);
          else begin
            resp      <= 32'h0000_00AA;
            resp_left <= 3'd1;
          end
        end
        READ_ISSUE: wait_cnt <= '0;
        READ_WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_cnt == WAIT_LAST) begin
            resp_left <= 3'd4;
            case (opcode)
              8'h02:   resp <= bus.inst_ext_out_data;
              8'h04:   resp <= bus.data_ext_out_data;
              default: resp <= bus.reg_ext_out_data;
            endcase
          end
        end
        RESP: if (bus.out_ready) begin
          resp      <= resp >> 8;
          resp_left <= resp_left - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready         = in_ready_c & ~reset;
  assign bus.out_valid        = out_valid_c;
  assign bus.out_data         = resp[7:0];
  assign bus.inst_ext_address = inst_addr;
  assign bus.inst_ext_write   = inst_we;
  assign bus.inst_ext_in_data = inst_wdata;
  assign bus.data_ext_address = data_addr;
  assign bus.data_ext_write   = data_we;
  assign bus.data_ext_in_data = data_wdata;
  assign bus.reg_ext_address  = reg_addr;
  assign bus.reg_ext_read     = reg_re;
  assign busy                 = (state != IDLE);

endmodule
